// File: rtl/spi_master_ctrl18.sv
// SPI master transfer sequencer: one command in, one complete SPI frame out, received word back with a done pulse.
// Optional LSB-first framing (extra input lsb_first18) is enabled by defining SPI18_LSB_FIRST_EN.
module spi_master_ctrl18 #(
  parameter int DATA_W = 32,
  parameter int DIV_W  = 8,
  parameter int LEN_W  = 5
) (
  input  logic              pclk18,
  input  logic              n_p_reset18,
  input  logic              start18,
  input  logic              abort18,
  input  logic [DATA_W-1:0] tx_data18,
  input  logic [LEN_W-1:0]  char_len18,
  input  logic              cpol18,
  input  logic              cpha18,
  input  logic [DIV_W-1:0]  clk_div18,
  input  logic [3:0]        ss_sel18,
`ifdef SPI18_LSB_FIRST_EN
  input  logic              lsb_first18,
`endif
  output logic              busy18,
  output logic              done18,
  output logic              ovr_err18,
  output logic [DATA_W-1:0] rx_data18,
  output logic              sclk_out18,
  output logic              n_sclk_en18,
  output logic [3:0]        n_ss_out18,
  output logic              n_ss_en18,
  output logic              mo18,
  output logic              n_mo_en18,
  input  logic              mi18
);

  localparam int CW = LEN_W + 1;
  localparam logic [CW-1:0] FULL_LEN = CW'(DATA_W);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [DIV_W-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]       bit_q, bit_d;
  logic                trail_q, trail_d;
  logic                cpol_q, cpol_d;
  logic                cpha_q, cpha_d;
  logic [DATA_W-1:0]   tx_sr_q, tx_sr_d;
  logic [DATA_W-1:0]   rx_sr_q, rx_sr_d;
  logic [DATA_W-1:0]   rx_data_q, rx_data_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                ovr_q, ovr_d;
  logic                sclk_q, sclk_d;
  logic                en_n_q, en_n_d;
  logic [3:0]          n_ss_q, n_ss_d;
  logic                mo_q, mo_d;

  logic                lsb_cmd, lsb_now;
  logic [CW-1:0]       cmd_len;
  logic [DATA_W-1:0]   tx_aligned, acc_next, tx_next, rx_ins;
  logic                acc_head, tx_head, half_end, accept;

`ifdef SPI18_LSB_FIRST_EN
  logic                lsb_q, lsb_d;
  logic [CW-1:0]       len_q, len_d;
  assign lsb_cmd = lsb_first18;
  assign lsb_now = lsb_q;
  // LSB-first receive inserts at bit L-1 so the word ends up right-aligned.
  assign rx_ins  = lsb_q ? ((rx_sr_q >> 1) | (DATA_W'(mi18) << (len_q - CW'(1))))
                         : {rx_sr_q[DATA_W-2:0], mi18};
`else
  assign lsb_cmd = 1'b0;
  assign lsb_now = 1'b0;
  assign rx_ins  = {rx_sr_q[DATA_W-2:0], mi18};
`endif

  assign cmd_len    = (char_len18 == '0) ? FULL_LEN : {1'b0, char_len18};
  // MSB-first frames are left-aligned so the first bit always sits in the top position.
  assign tx_aligned = lsb_cmd ? tx_data18 : (tx_data18 << (FULL_LEN - cmd_len));
  assign acc_head   = lsb_cmd ? tx_aligned[0] : tx_aligned[DATA_W-1];
  assign acc_next   = lsb_cmd ? (tx_aligned >> 1) : (tx_aligned << 1);
  assign tx_head    = lsb_now ? tx_sr_q[0] : tx_sr_q[DATA_W-1];
  assign tx_next    = lsb_now ? (tx_sr_q >> 1) : (tx_sr_q << 1);
  assign half_end   = (cnt_q == div_q);
  assign accept     = start18 && ((state_q == S_IDLE) || (state_q == S_DONE));

  always_comb begin
    // NOTE: every _d takes its _q value first, so no path through this block can infer a latch.
    state_d   = state_q;
    div_d     = div_q;
    cnt_d     = half_end ? '0 : cnt_q + 1'b1;
    bit_d     = bit_q;
    trail_d   = trail_q;
    cpol_d    = cpol_q;
    cpha_d    = cpha_q;
    tx_sr_d   = tx_sr_q;
    rx_sr_d   = rx_sr_q;
    rx_data_d = rx_data_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    ovr_d     = start18 && busy_q;
    sclk_d    = sclk_q;
    en_n_d    = en_n_q;
    n_ss_d    = n_ss_q;
    mo_d      = mo_q;
`ifdef SPI18_LSB_FIRST_EN
    lsb_d     = lsb_q;
    len_d     = len_q;
`endif

    unique case (state_q)
      S_IDLE: cnt_d = '0;
      S_SETUP: begin
        if (half_end) begin
          state_d = S_SHIFT;
          trail_d = 1'b0;
        end
      end
      S_SHIFT: begin
        if (half_end) begin
          sclk_d = ~sclk_q;
          if (!trail_q) begin
            if (cpha_q) begin
              mo_d    = tx_head;
              tx_sr_d = tx_next;
            end else begin
              rx_sr_d = rx_ins;
            end
            trail_d = 1'b1;
          end else begin
            if (cpha_q) begin
              rx_sr_d = rx_ins;
            end else begin
              mo_d    = tx_head;
              tx_sr_d = tx_next;
            end
            trail_d = 1'b0;
            bit_d   = bit_q - CW'(1);
            if (bit_q == CW'(1)) state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (half_end) begin
          state_d   = S_DONE;
          done_d    = 1'b1;
          rx_data_d = rx_sr_q;
          busy_d    = 1'b0;
          n_ss_d    = 4'hF;
          en_n_d    = 1'b1;
          mo_d      = 1'b0;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      state_d = S_SETUP;
      cnt_d   = '0;
      busy_d  = 1'b1;
      cpol_d  = cpol18;
      cpha_d  = cpha18;
      div_d   = clk_div18;
      bit_d   = cmd_len;
      trail_d = 1'b0;
      rx_sr_d = '0;
      sclk_d  = cpol18;
      en_n_d  = 1'b0;
      n_ss_d  = ~ss_sel18;
      // With cpha=0 the first bit must already be on MOSI before the first edge.
      mo_d    = cpha18 ? 1'b0 : acc_head;
      tx_sr_d = cpha18 ? tx_aligned : acc_next;
`ifdef SPI18_LSB_FIRST_EN
      lsb_d   = lsb_first18;
      len_d   = cmd_len;
`endif
    end

    // Abort wins over a done that would complete in the same cycle.
    if (busy_q && abort18) begin
      state_d   = S_IDLE;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      rx_data_d = rx_data_q;
      sclk_d    = cpol_q;
      en_n_d    = 1'b1;
      n_ss_d    = 4'hF;
      mo_d      = 1'b0;
    end
  end

  always_ff @(posedge pclk18 or negedge n_p_reset18) begin
    // NOTE: state is updated only with non-blocking assignments so every flop samples pre-edge values.
    if (!n_p_reset18) begin
      state_q   <= S_IDLE;
      div_q     <= '0;
      cnt_q     <= '0;
      bit_q     <= '0;
      trail_q   <= 1'b0;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      tx_sr_q   <= '0;
      rx_sr_q   <= '0;
      rx_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovr_q     <= 1'b0;
      sclk_q    <= 1'b0;
      en_n_q    <= 1'b1;
      n_ss_q    <= 4'hF;
      mo_q      <= 1'b0;
`ifdef SPI18_LSB_FIRST_EN
      lsb_q     <= 1'b0;
      len_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      trail_q   <= trail_d;
      cpol_q    <= cpol_d;
      cpha_q    <= cpha_d;
      tx_sr_q   <= tx_sr_d;
      rx_sr_q   <= rx_sr_d;
      rx_data_q <= rx_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ovr_q     <= ovr_d;
      sclk_q    <= sclk_d;
      en_n_q    <= en_n_d;
      n_ss_q    <= n_ss_d;
      mo_q      <= mo_d;
`ifdef SPI18_LSB_FIRST_EN
      lsb_q     <= lsb_d;
      len_q     <= len_d;
`endif
    end
  end

  assign busy18      = busy_q;
  assign done18      = done_q;
  assign ovr_err18   = ovr_q;
  assign rx_data18   = rx_data_q;
  assign sclk_out18  = sclk_q;
  assign n_sclk_en18 = en_n_q;
  assign n_ss_out18  = n_ss_q;
  assign n_ss_en18   = en_n_q;
  assign mo18        = mo_q;
  assign n_mo_en18   = en_n_q;

endmodule

// File: tb/tb_spi_master_ctrl18.sv
// Self-checking bench for spi_master_ctrl18: received words go through a scoreboard queue, frame timing checked inline.
module tb_spi_master_ctrl18;

  logic        pclk18 = 1'b0;
  logic        n_p_reset18;
  logic        start18, abort18;
  logic [31:0] tx_data18;
  logic [4:0]  char_len18;
  logic        cpol18, cpha18;
  logic [7:0]  clk_div18;
  logic [3:0]  ss_sel18;
  logic        busy18, done18, ovr_err18;
  logic [31:0] rx_data18;
  logic        sclk_out18, n_sclk_en18, n_ss_en18, mo18, n_mo_en18, mi18;
  logic [3:0]  n_ss_out18;

  spi_master_ctrl18 dut (
    .pclk18(pclk18), .n_p_reset18(n_p_reset18), .start18(start18), .abort18(abort18),
    .tx_data18(tx_data18), .char_len18(char_len18), .cpol18(cpol18), .cpha18(cpha18),
    .clk_div18(clk_div18), .ss_sel18(ss_sel18), .busy18(busy18), .done18(done18),
    .ovr_err18(ovr_err18), .rx_data18(rx_data18), .sclk_out18(sclk_out18),
    .n_sclk_en18(n_sclk_en18), .n_ss_out18(n_ss_out18), .n_ss_en18(n_ss_en18),
    .mo18(mo18), .n_mo_en18(n_mo_en18), .mi18(mi18)
  );

  always #5 pclk18 = ~pclk18;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];

  // Slave model: loopback, or a 16-bit word presented after each leading sclk edge.
  logic        tb_loop = 1'b1;
  logic        tb_cpol = 1'b0;
  logic [15:0] slv_word = '0;
  int          lead_cnt = 0;
  int          rise_cnt = 0;

  assign mi18 = tb_loop ? mo18 :
                ((lead_cnt >= 1 && lead_cnt <= 16) ? slv_word[16 - lead_cnt] : 1'b0);

  always @(sclk_out18) if (sclk_out18 !== tb_cpol) lead_cnt = lead_cnt + 1;
  always @(posedge sclk_out18) rise_cnt = rise_cnt + 1;

  // Scoreboard: every done pulse pops one expected word.
  always @(negedge pclk18) begin
    if (n_p_reset18 === 1'b1 && done18 === 1'b1) begin
      logic [31:0] exp_w;
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_done: rx_data18=%h, no frame outstanding", rx_data18);
      end else begin
        exp_w = exp_q.pop_front();
        if (rx_data18 !== exp_w) begin
          n_fail++;
          $display("FAIL rx_data: got %h expected %h", rx_data18, exp_w);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic set_cmd(input logic [31:0] tx, input logic [4:0] len, input logic pol,
                         input logic pha, input logic [7:0] div, input logic [3:0] ss);
    tx_data18 = tx; char_len18 = len; cpol18 = pol; cpha18 = pha;
    clk_div18 = div; ss_sel18 = ss; tb_cpol = pol;
  endtask

  // Drives start for one cycle; returns at the negedge of cycle 1.
  task automatic pulse_start();
    start18 = 1'b1;
    @(negedge pclk18);
    start18 = 1'b0;
  endtask

  // Waits from cycle 1 for done18, flagging any busy cycle with wrong busy/ss.
  task automatic run_to_done(input logic [3:0] ss_exp, output int cyc, output bit ss_bad);
    cyc = 1; ss_bad = 1'b0;
    while (done18 !== 1'b1 && cyc < 600) begin
      if (busy18 !== 1'b1 || n_ss_out18 !== ss_exp) ss_bad = 1'b1;
      @(negedge pclk18);
      cyc++;
    end
  endtask

  task automatic test_reset();
    n_p_reset18 = 1'b0; start18 = 1'b0; abort18 = 1'b0;
    set_cmd(32'h0, 5'd8, 1'b0, 1'b0, 8'd0, 4'h0);
    repeat (3) @(negedge pclk18);
    n_tests++;
    if ({busy18, done18, ovr_err18, sclk_out18, mo18} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: busy/done/ovr/sclk/mo=%b expected 00000",
               {busy18, done18, ovr_err18, sclk_out18, mo18});
    end
    n_tests++;
    if ({n_sclk_en18, n_ss_en18, n_mo_en18} !== 3'b111) begin
      n_fail++;
      $display("FAIL reset_enables: got %b expected 111", {n_sclk_en18, n_ss_en18, n_mo_en18});
    end
    n_tests++;
    if (n_ss_out18 !== 4'hF) begin
      n_fail++;
      $display("FAIL reset_ss: got %h expected f", n_ss_out18);
    end
    n_tests++;
    if (rx_data18 !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_rx: got %h expected 0", rx_data18);
    end
    n_p_reset18 = 1'b1;
    @(negedge pclk18);
  endtask

  task automatic test_mode0();
    int cyc; bit ss_bad;
    set_cmd(32'h0000_00A5, 5'd8, 1'b0, 1'b0, 8'd1, 4'b0010);
    tb_loop = 1'b1; rise_cnt = 0;
    exp_q.push_back(32'h0000_00A5);
    n_tests++;
    if (n_ss_out18 !== 4'hF || busy18 !== 1'b0) begin
      n_fail++;
      $display("FAIL m0_pre_idle: n_ss=%h busy=%b expected f/0", n_ss_out18, busy18);
    end
    pulse_start();
    n_tests++;
    if (busy18 !== 1'b1 || {n_sclk_en18, n_ss_en18, n_mo_en18} !== 3'b000) begin
      n_fail++;
      $display("FAIL m0_busy_c1: busy=%b en=%b expected 1/000", busy18,
               {n_sclk_en18, n_ss_en18, n_mo_en18});
    end
    run_to_done(4'b1101, cyc, ss_bad);
    n_tests++;
    if (cyc !== 37) begin
      n_fail++;
      $display("FAIL m0_latency: done at cycle %0d expected 37", cyc);
    end
    n_tests++;
    if (ss_bad) begin
      n_fail++;
      $display("FAIL m0_ss_busy: busy/n_ss deviated during frame, expected busy=1 n_ss=d");
    end
    n_tests++;
    if (n_ss_out18 !== 4'hF || busy18 !== 1'b0) begin
      n_fail++;
      $display("FAIL m0_done_release: n_ss=%h busy=%b expected f/0", n_ss_out18, busy18);
    end
    n_tests++;
    if (rise_cnt !== 8) begin
      n_fail++;
      $display("FAIL m0_sclk_rises: got %0d expected 8", rise_cnt);
    end
    @(negedge pclk18);
    n_tests++;
    if (done18 !== 1'b0) begin
      n_fail++;
      $display("FAIL m0_done_pulse: done18=%b one cycle later, expected 0", done18);
    end
  endtask

  task automatic test_mode3();
    int cyc; bit ss_bad;
    set_cmd(32'h0000_1234, 5'd16, 1'b1, 1'b1, 8'd0, 4'b1000);
    tb_loop = 1'b0; slv_word = 16'h3C5A; lead_cnt = 0;
    exp_q.push_back(32'h0000_3C5A);
    pulse_start();
    n_tests++;
    if (sclk_out18 !== 1'b1) begin
      n_fail++;
      $display("FAIL m3_sclk_before: got %b expected 1", sclk_out18);
    end
    run_to_done(4'b0111, cyc, ss_bad);
    n_tests++;
    if (cyc !== 35 || ss_bad) begin
      n_fail++;
      $display("FAIL m3_latency: done at cycle %0d ss_bad=%0d expected 35/0", cyc, ss_bad);
    end
    @(negedge pclk18);
    n_tests++;
    if (sclk_out18 !== 1'b1) begin
      n_fail++;
      $display("FAIL m3_sclk_after: got %b expected 1", sclk_out18);
    end
    tb_loop = 1'b1;
  endtask

  task automatic test_full_len();
    int cyc; bit ss_bad;
    set_cmd(32'hDEAD_BEEF, 5'd0, 1'b0, 1'b0, 8'd2, 4'b0001);
    exp_q.push_back(32'hDEAD_BEEF);
    pulse_start();
    run_to_done(4'b1110, cyc, ss_bad);
    n_tests++;
    if (cyc !== 1 + 66 * 3 || ss_bad) begin
      n_fail++;
      $display("FAIL len0_latency: done at cycle %0d ss_bad=%0d expected %0d/0", cyc, ss_bad, 1 + 66 * 3);
    end
    @(negedge pclk18);
  endtask

  task automatic test_back_to_back();
    int cyc; int ovr_cnt; bit ss_bad;
    set_cmd(32'h0000_003C, 5'd8, 1'b0, 1'b0, 8'd0, 4'b0100);
    exp_q.push_back(32'h0000_003C);
    pulse_start();
    cyc = 1; ovr_cnt = 0;
    while (done18 !== 1'b1 && cyc < 200) begin
      if (ovr_err18 === 1'b1) ovr_cnt++;
      if (cyc == 5) begin
        start18 = 1'b1; tx_data18 = 32'hFF;
      end else begin
        start18 = 1'b0;
      end
      @(negedge pclk18);
      cyc++;
    end
    n_tests++;
    if (cyc !== 19) begin
      n_fail++;
      $display("FAIL b2b_first_latency: done at cycle %0d expected 19", cyc);
    end
    set_cmd(32'h0000_005A, 5'd8, 1'b0, 1'b0, 8'd0, 4'b0100);
    exp_q.push_back(32'h0000_005A);
    pulse_start();
    n_tests++;
    if (busy18 !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_no_gap: busy18=%b after start in done cycle, expected 1", busy18);
    end
    if (ovr_err18 === 1'b1) ovr_cnt++;
    run_to_done(4'b1011, cyc, ss_bad);
    n_tests++;
    if (cyc !== 19 || ss_bad) begin
      n_fail++;
      $display("FAIL b2b_second_latency: done at cycle %0d ss_bad=%0d expected 19/0", cyc, ss_bad);
    end
    n_tests++;
    if (ovr_cnt !== 1) begin
      n_fail++;
      $display("FAIL ovr_pulses: got %0d expected 1", ovr_cnt);
    end
    @(negedge pclk18);
  endtask

  task automatic test_abort();
    int dones;
    set_cmd(32'h0000_0081, 5'd8, 1'b0, 1'b0, 8'd1, 4'b0010);
    pulse_start();
    repeat (14) @(negedge pclk18);
    abort18 = 1'b1;
    @(negedge pclk18);
    abort18 = 1'b0;
    n_tests++;
    if (busy18 !== 1'b0 || n_ss_out18 !== 4'hF) begin
      n_fail++;
      $display("FAIL abort_release: busy=%b n_ss=%h expected 0/f", busy18, n_ss_out18);
    end
    n_tests++;
    if ({n_sclk_en18, n_ss_en18, n_mo_en18, sclk_out18} !== 4'b1110) begin
      n_fail++;
      $display("FAIL abort_enables: en/sclk=%b expected 1110",
               {n_sclk_en18, n_ss_en18, n_mo_en18, sclk_out18});
    end
    dones = 0;
    repeat (60) begin
      if (done18 === 1'b1) dones++;
      @(negedge pclk18);
    end
    n_tests++;
    if (dones !== 0 || rx_data18 !== 32'h0000_005A) begin
      n_fail++;
      $display("FAIL abort_no_done: dones=%0d rx=%h expected 0/0000005a", dones, rx_data18);
    end
  endtask

  task automatic test_reset_mid();
    int cyc; bit ss_bad;
    set_cmd(32'h0000_00C3, 5'd8, 1'b1, 1'b1, 8'd1, 4'b0001);
    pulse_start();
    repeat (9) @(negedge pclk18);
    n_p_reset18 = 1'b0;
    #1;
    n_tests++;
    if ({busy18, done18, ovr_err18, sclk_out18, mo18, n_sclk_en18, n_ss_en18, n_mo_en18, n_ss_out18}
        !== 12'b00000_111_1111 || rx_data18 !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mid: outs=%b rx=%h expected 000001111111/0",
               {busy18, done18, ovr_err18, sclk_out18, mo18, n_sclk_en18, n_ss_en18, n_mo_en18, n_ss_out18},
               rx_data18);
    end
    @(negedge pclk18);
    n_p_reset18 = 1'b1;
    @(negedge pclk18);
    set_cmd(32'h0000_0096, 5'd8, 1'b0, 1'b0, 8'd0, 4'b0100);
    exp_q.push_back(32'h0000_0096);
    pulse_start();
    run_to_done(4'b1011, cyc, ss_bad);
    n_tests++;
    if (cyc !== 19 || ss_bad) begin
      n_fail++;
      $display("FAIL reset_restart: done at cycle %0d ss_bad=%0d expected 19/0", cyc, ss_bad);
    end
    @(negedge pclk18);
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_mode3();
    test_full_len();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    repeat (5) @(negedge pclk18);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d frames outstanding, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_master_ctrl18.md
Name: spi_master_ctrl18

Overview:
Transfer sequencer for the SPI master port: takes one command (tx word, length, mode, divider, slave select) from the register/APB side and drives one complete SPI frame. Generates sclk, slave selects, MOSI and the output enables, samples MISO, and returns the received word with a done pulse. It sits between the SPI register block and the master-side pins (sig_mo/sig_mi/sig_sclk_out/sig_n_ss_out and their enables) driven through spi_if18.

Parameters:
DATA_W, 32, maximum frame length in bits; also the width of tx_data18 and rx_data18.
DIV_W, 8, width of the clock-divider field.
LEN_W, 5, width of the char_len field; must satisfy 2**LEN_W == DATA_W.

Ports:
pclk18  in  1  system clock; the only clock.
n_p_reset18  in  1  asynchronous active-low reset.
start18  in  1  single-cycle transfer request.
abort18  in  1  terminate the current transfer.
tx_data18  in  DATA_W  word to transmit; bit 0 is sent last (MSB-first).
char_len18  in  LEN_W  frame length in bits; 0 encodes DATA_W.
cpol18  in  1  sclk idle level.
cpha18  in  1  clock phase.
clk_div18  in  DIV_W  half-period is clk_div18+1 pclk cycles.
ss_sel18  in  4  one-hot slave select; all-zero is legal and asserts no slave.
busy18  out  1  transfer in progress.
done18  out  1  one-cycle pulse; rx_data18 is valid in the same cycle.
ovr_err18  out  1  one-cycle pulse when start18 arrives while busy.
rx_data18  out  DATA_W  received word, right-aligned, upper bits 0; held until the next done.
sclk_out18  out  1  SPI clock.
n_sclk_en18  out  1  sclk output enable, active-low.
n_ss_out18  out  4  slave selects, active-low.
n_ss_en18  out  1  slave-select output enable, active-low.
mo18  out  1  MOSI.
n_mo_en18  out  1  MOSI output enable, active-low.
mi18  in  1  MISO.

Behaviour:
- Clock and reset: single clock pclk18. Reset n_p_reset18 is asynchronous, active-low.
- Reset values: busy18=0, done18=0, ovr_err18=0, rx_data18=0, sclk_out18=0, n_sclk_en18=1, n_ss_out18=4'hF, n_ss_en18=1, mo18=0, n_mo_en18=1. FSM state is IDLE.
- Command capture: start18 is sampled only in IDLE. On acceptance, all command inputs are latched, and later changes to them have no effect.
- Notation: H = clk_div18+1 pclk cycles; L = char_len18, or DATA_W when char_len18==0.
- IDLE:
  - sclk_out18 = latched cpol18.
  - All enables inactive, n_ss_out18 = 4'hF.
  - start18 moves the FSM to SETUP on the next edge.
- SETUP (H cycles):
  - busy18=1; enables active (0); n_ss_out18 = ~ss_sel18.
  - mo18 = first bit when cpha18=0, else 0.
- SHIFT (2*L half-periods):
  - sclk_out18 toggles at the end of each half-period.
  - cpha18=0: sample mi18 on the leading edge, shift mo18 on the trailing edge.
  - cpha18=1: shift mo18 on the leading edge, sample mi18 on the trailing edge.
  - A bit counter counts down from L; SHIFT exits after the final trailing edge.
- HOLD (H cycles): sclk_out18 at idle level, ss still asserted.
- DONE (1 cycle):
  - done18=1, rx_data18 updated, busy18=0.
  - n_ss_out18=4'hF, enables inactive.
  - Next state is IDLE. A start18 in this cycle is accepted, giving back-to-back frames.
- Latency: done18 is asserted (2L+2)·H cycles after the first busy cycle.
- start18 while busy18=1: ignored, and ovr_err18 pulses for 1 cycle.
- abort18 in any busy state: next cycle is IDLE, sclk returns to idle, ss and enables are released, no done18, rx_data18 unchanged. abort18 in IDLE has no effect. abort18 takes priority over a simultaneous done.
- Divider: clk_div18=0 gives H=1, i.e. sclk = pclk/2.
- Reset mid-transfer: all outputs immediately take their reset values.

Optional Feature:
Macro SPI18_LSB_FIRST_EN.
- Defined: adds input lsb_first18 (1 bit), latched at start18. When lsb_first18=1, tx_data18 bit 0 is sent first and received bits fill from bit L-1 downward, so rx_data18 stays right-aligned.
- Undefined: no port, MSB-first only.

Test Plan:
1. Mode 0, clk_div18=1, L=8, tx 0xA5, mi18 tied to mo18, start at cycle 0 -> busy18 1 at cycle 1; done18 at cycle 37; rx_data18=0x000000A5; exactly 8 sclk rising edges; n_ss_out18 = ~ss_sel18 only while busy.
2. Mode 3 (cpol18=1, cpha18=1), clk_div18=0, L=16, slave model returns 0x3C5A -> rx_data18=0x00003C5A; sclk idles high before and after the frame.
3. char_len18=0, tx 0xDEADBEEF, loopback -> 32-bit frame, rx_data18=0xDEADBEEF, done18 after 66·H cycles.
4. start18 pulsed mid-frame -> ovr_err18 pulses once; frame and rx_data18 unaffected; a start18 in the DONE cycle launches a second frame with no idle gap.
5. abort18 after 3 bits -> next cycle busy18=0, n_ss_out18=4'hF, all enables 1, no done18, rx_data18 keeps its previous value.
6. n_p_reset18 asserted mid-SHIFT -> all outputs at reset values in the same cycle; a new start18 after release completes normally.
